// File: rtl/alu_execute_unit.sv
// alu_execute_unit
// Execute-stage datapath behind alu_controller. It accepts an op code and two
// operands over a valid/ready handshake and returns a registered result.
// Logic, arithmetic and compare ops finish in one cycle. Shifts either run
// one bit per cycle or, with ALU_FAST_SHIFT_EN defined, use a barrel shifter.
//
// Build option:
//   ALU_FAST_SHIFT_EN : single-cycle barrel shifter, no SHIFT state or counter.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  request handshake
//   alu_operation_i      4-bit op code
//   operand_a_i/_b_i     XLEN-bit operands (shift amount = operand_b_i[SHAMT_W-1:0])
//   flush_i              synchronous abort of any in-flight op
//   out_valid_o/out_ready_i  result handshake
//   result_o, zero_o, illegal_op_o  registered result and its flags
//   busy_o               unit is not idle
module alu_execute_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      alu_operation_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_op_o,
  output logic            busy_o
);

  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic op_legal_f(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
      OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: op_legal_f = 1'b1;
      default:                               op_legal_f = 1'b0;
    endcase
  endfunction

  function automatic logic is_shift_f(input logic [3:0] op);
    is_shift_f = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Single-cycle ops. In the iterative build a shift here only covers the
  // zero-amount case, so it simply passes operand a through.
  function automatic logic [XLEN-1:0] alu_f(input logic [3:0]      op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [XLEN-1:0]        r;
    a_s = a;
    b_s = b;
    r   = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  r = a << b[SHAMT_W-1:0];
      OP_SRL:  r = a >> b[SHAMT_W-1:0];
      OP_SRA:  r = a_s >>> b[SHAMT_W-1:0];
`else
      OP_SLL, OP_SRL, OP_SRA: r = a;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

`ifndef ALU_FAST_SHIFT_EN
  // One-bit step of the iterative shifter.
  function automatic logic [XLEN-1:0] shift1_f(input logic [3:0]      op,
                                               input logic [XLEN-1:0] acc);
    case (op)
      OP_SLL:  shift1_f = {acc[XLEN-2:0], 1'b0};
      OP_SRA:  shift1_f = {acc[XLEN-1], acc[XLEN-1:1]};
      default: shift1_f = {1'b0, acc[XLEN-1:1]};
    endcase
  endfunction
`endif

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] alu_res;
  logic            accept;
  logic            start_shift;

`ifndef ALU_FAST_SHIFT_EN
  logic [XLEN-1:0]    acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [XLEN-1:0]    acc_step;
`endif

  assign in_ready_o   = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
  assign accept       = in_valid_i && in_ready_o && !flush_i;
  assign out_valid_o  = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign result_o     = result_q;
  assign zero_o       = zero_q;
  assign illegal_op_o = illegal_q;
  assign alu_res      = alu_f(alu_operation_i, operand_a_i, operand_b_i);

`ifdef ALU_FAST_SHIFT_EN
  assign start_shift = 1'b0;
`else
  assign start_shift = is_shift_f(alu_operation_i) &&
                       (operand_b_i[SHAMT_W-1:0] != '0);
  assign acc_step    = shift1_f(op_q, acc_q);
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifndef ALU_FAST_SHIFT_EN
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
`endif
    if (flush_i) begin
      // Abort wins over everything; the last delivered result stays visible.
      state_d = IDLE;
    end else if (accept && start_shift) begin
`ifndef ALU_FAST_SHIFT_EN
      acc_d = operand_a_i;
      cnt_d = operand_b_i[SHAMT_W-1:0];
      op_d  = alu_operation_i;
`endif
      state_d = SHIFT;
    end else if (accept) begin
      result_d  = alu_res;
      zero_d    = (alu_res == '0);
      illegal_d = !op_legal_f(alu_operation_i);
      state_d   = DONE;
    end else begin
      case (state_q)
`ifndef ALU_FAST_SHIFT_EN
        SHIFT: begin
          acc_d = acc_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == SHAMT_W'(1)) begin
            result_d  = acc_step;
            zero_d    = (acc_step == '0);
            illegal_d = 1'b0;
            state_d   = DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready_i) state_d = IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

`ifndef ALU_FAST_SHIFT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Shift accumulator and latched op are only meaningful inside SHIFT.
  always_ff @(posedge clk_i) begin
    acc_q <= acc_d;
    op_q  <= op_d;
  end
`endif

endmodule
